// File: rtl/sd1001_stream_ctrl.sv
// Word-to-serial sequencer for an external "1001" Moore detector.
// Shifts an accepted word MSB-first into the detector, samples the detector's
// output one cycle behind each bit, and returns match count and first-match index.
module sd1001_stream_ctrl #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 4,
   parameter int unsigned IW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          det_in,
   input  logic          det_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [CW-1:0] res_count,
   output logic [IW-1:0] res_first,
   output logic          busy
);

   localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;

   // Remaining bits still to be shifted; the MSB goes out at the accept edge.
   logic [W-2:0]  sr_q, sr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] first_q, first_d;
   logic          found_q, found_d;

   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;
   logic          res_valid_q, res_valid_d;
   logic          det_in_q, det_in_d;

   logic          accept_c;
   logic          sample_c;
   logic [IW-1:0] sample_idx_c;

   assign accept_c = (state_q == S_IDLE) && in_valid;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (in_valid)             state_d = S_SHIFT;
         S_SHIFT: if (idx_q == LAST_IDX)    state_d = S_DRAIN;
         S_DRAIN:                           state_d = S_DONE;
         S_DONE:  if (res_ready)            state_d = S_IDLE;
         default:                           state_d = S_IDLE;
      endcase
   end

   // Output next values, registered so every port is driven from a flop.
   always_comb begin
      in_ready_d  = (state_d == S_IDLE);
      busy_d      = (state_d == S_SHIFT) || (state_d == S_DRAIN);
      res_valid_d = (state_d == S_DONE);
      det_in_d    = 1'b0;
      if (accept_c) begin
         det_in_d = in_data[W-1];
      end else if ((state_q == S_SHIFT) && (idx_q != LAST_IDX)) begin
         det_in_d = sr_q[W-2];
      end
   end

   // Datapath: shift register, bit index and match bookkeeping.
   always_comb begin
      sr_d         = sr_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
      found_d      = found_q;
      // det_out lags det_in by one cycle, so it reports the previous bit.
      sample_c     = ((state_q == S_SHIFT) && (idx_q != '0)) || (state_q == S_DRAIN);
      sample_idx_c = (state_q == S_DRAIN) ? LAST_IDX : IW'(idx_q - IW'(1));
      if (accept_c) begin
         sr_d    = in_data[W-2:0];
         idx_d   = '0;
         cnt_d   = '0;
         first_d = '0;
         found_d = 1'b0;
      end else begin
         if (state_q == S_SHIFT) begin
            sr_d  = {sr_q[W-3:0], 1'b0};
            idx_d = IW'(idx_q + IW'(1));
         end
         if (sample_c && det_out) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = CW'(cnt_q + CW'(1));
            end
            if (!found_q) begin
               found_d = 1'b1;
               first_d = sample_idx_c;
            end
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q        <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         first_q     <= '0;
         found_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         det_in_q    <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         found_q     <= found_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         det_in_q    <= det_in_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign det_in    = det_in_q;
   assign res_count = cnt_q;
   assign res_first = first_q;

endmodule

// File: tb/tb_sd1001_stream_ctrl.sv
// Bench for sd1001_stream_ctrl: behavioural "1001" Moore detector on the serial
// side, directed plus random words, results checked against a string-search model.
module tb_sd1001_stream_ctrl;

   localparam int unsigned W    = 8;
   localparam int unsigned CW   = 4;
   localparam int unsigned IW   = 3;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          det_in;
   logic          det_out;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_count;
   logic [IW-1:0] res_first;
   logic          busy;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sd1001_stream_ctrl #(.W(W), .CW(CW), .IW(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .det_in    (det_in),
      .det_out   (det_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_count (res_count),
      .res_first (res_first),
      .busy      (busy)
   );

   // External detector: tracks progress through "1001", overlapping matches allowed.
   // 0: nothing, 1: "1", 2: "10", 3: "100", 4: "1001" (output high).
   int det_st;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         det_st <= 0;
      end else begin
         case (det_st)
            0:       det_st <= det_in ? 1 : 0;
            1:       det_st <= det_in ? 1 : 2;
            2:       det_st <= det_in ? 1 : 3;
            3:       det_st <= det_in ? 4 : 0;
            default: det_st <= det_in ? 1 : 2;
         endcase
      end
   end
   assign det_out = (det_st == 4);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scan the word in shift order for every "1001" ending position.
   function automatic void ref_model(input logic [W-1:0] d, output int cnt, output int first);
      logic [W-1:0] s;
      for (int i = 0; i < W; i++) s[i] = d[W-1-i];
      cnt   = 0;
      first = 0;
      for (int i = 3; i < W; i++) begin
         if (s[i-3] && !s[i-2] && !s[i-1] && s[i]) begin
            if (cnt == 0) first = i;
            cnt++;
         end
      end
      if (cnt > CMAX) cnt = CMAX;
   endfunction

   // Entered and left at a falling edge with the controller in IDLE.
   task automatic run_word(input logic [W-1:0] d, input int hold, input int ecnt, input int efirst);
      int busy_n;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      busy_n   = 0;
      for (int i = 0; i < W; i++) begin
         in_data = W'($urandom);
         chk("det_in_shift", 32'(det_in), 32'(d[W-1-i]));
         chk("res_valid_shift", 32'(res_valid), 32'd0);
         chk("in_ready_shift", 32'(in_ready), 32'd0);
         if (busy) busy_n++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("det_in_drain", 32'(det_in), 32'd0);
      chk("res_valid_drain", 32'(res_valid), 32'd0);
      if (busy) busy_n++;
      @(posedge clk);
      @(negedge clk);
      if (busy) busy_n++;
      chk("busy_cycles", 32'(busy_n), 32'(W + 1));
      chk("res_valid_done", 32'(res_valid), 32'd1);
      chk("res_count", 32'(res_count), 32'(ecnt));
      chk("res_first", 32'(res_first), 32'(efirst));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      chk("det_in_done", 32'(det_in), 32'd0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("hold_res_valid", 32'(res_valid), 32'd1);
         chk("hold_res_count", 32'(res_count), 32'(ecnt));
         chk("hold_res_first", 32'(res_first), 32'(efirst));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_busy", 32'(busy), 32'd0);
      end
      // Offer a word while consuming the result: it must not be taken.
      res_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      in_valid  = 1'b0;
      chk("after_done_res_valid", 32'(res_valid), 32'd0);
      chk("after_done_in_ready", 32'(in_ready), 32'd1);
      chk("after_done_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] w;
      int           ec;
      int           ef;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_det_in", 32'(det_in), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_count", 32'(res_count), 32'd0);
      chk("rst_res_first", 32'(res_first), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_det_in", 32'(det_in), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Directed words.
      run_word(8'b1001_0010, 0, 2, 3);
      run_word(8'b0000_0000, 0, 0, 0);
      run_word(8'b1111_1111, 0, 0, 0);
      run_word(8'b0000_0100, 0, 0, 0);
      run_word(8'b1000_0000, 0, 0, 0);
      run_word(8'b0001_0011, 0, 1, 6);
      run_word(8'b0110_1001, 5, 1, 7);

      // Reset in the middle of a word.
      in_valid = 1'b1;
      in_data  = 8'b1001_1001;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("abort_det_in_idx4", 32'(det_in), 32'd1);
      chk("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_det_in", 32'(det_in), 32'd0);
      chk("abort_res_count", 32'(res_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("abort_no_res_valid", 32'(res_valid), 32'd0);
         chk("abort_idle_busy", 32'(busy), 32'd0);
      end
      run_word(8'b1001_1001, 0, 2, 3);

      // Random words with random consumer stalls.
      for (int k = 0; k < 30; k++) begin
         w = W'($urandom);
         if (k % 3 == 0) w = 8'b1001_0000 | W'($urandom_range(0, 15));
         ref_model(w, ec, ef);
         run_word(w, int'($urandom_range(0, 3)), ec, ef);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
